// File: rtl/mat_pkg.sv
// Shared definitions for the matrix datapath: output-streamer state encoding and
// the matrix size derivations used by the streamer and the address generator.
package mat_pkg;

    localparam int DIM_LOG_DEFAULT    = 1;
    localparam int DATA_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } stream_state_e;

    // Address width of a square matrix of side 2**dim_log, stored row-major.
    function automatic int calc_size_log(input int dim_log);
        return 2 * dim_log;
    endfunction

    function automatic int calc_size(input int dim_log);
        return 1 << (2 * dim_log);
    endfunction

endpackage

// File: rtl/axis_skid_fifo.sv
// Two-entry FIFO between the result-BRAM read port and the AXI-Stream master.
// A push and a pop in the same cycle leave the occupancy unchanged.
module axis_skid_fifo #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/mat_out_streamer.sv
// Streams the completed result matrix out of the result BRAM as one AXI-Stream packet,
// reading addresses 0..SIZE-1 in row-major order through a 2-entry FIFO.
module mat_out_streamer
    import mat_pkg::*;
#(
    parameter int DIM_LOG    = DIM_LOG_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int SIZE_LOG   = calc_size_log(DIM_LOG),
    parameter int SIZE       = calc_size(DIM_LOG)
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_areset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [SIZE_LOG-1:0]     rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    m00_axis_tvalid,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tlast,
    input  logic                    m00_axis_tready
);

    localparam logic [SIZE_LOG:0]   LP_SIZE     = (SIZE_LOG + 1)'(SIZE);
    localparam logic [SIZE_LOG-1:0] LP_LAST_IDX = SIZE_LOG'(SIZE - 1);

    stream_state_e         r_state;
    stream_state_e         w_state_next;
    logic [SIZE_LOG:0]     r_rd_cnt;
    logic [SIZE_LOG-1:0]   r_beat_cnt;
    logic                  r_inflight;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [DATA_WIDTH-1:0] w_fifo_data;
    logic                  w_valid;
    logic                  w_beat;
    logic                  w_last_beat;
    logic                  w_reads_left;
    logic                  w_rd_en;
    logic                  w_busy;
    logic                  w_done;
    logic [1:0]            w_occ;
    logic [2:0]            w_pending;

    axis_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .i_clk   (s00_axi_aclk),
        .i_rst   (s00_axi_areset),
        .i_push  (r_inflight),
        .i_data  (rd_data),
        .i_pop   (w_beat),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_valid      = !w_fifo_empty && (r_state == S_STREAM);
    assign w_beat       = w_valid && m00_axis_tready;
    assign w_last_beat  = (r_beat_cnt == LP_LAST_IDX);
    assign w_reads_left = (r_rd_cnt < LP_SIZE);
    assign w_occ        = w_fifo_full ? 2'd2 : (w_fifo_empty ? 2'd0 : 2'd1);

    // Credit counts the entry leaving this cycle, so a full-rate stream keeps one read in flight.
    assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_beat};
    assign w_rd_en   = (r_state == S_STREAM) && w_reads_left && (w_pending < 3'd2);

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                w_busy = 1'b1;
                if (w_beat && w_last_beat) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Read and beat counters run independently so tlast follows the data actually sent.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            r_rd_cnt   <= '0;
            r_beat_cnt <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (r_state != S_STREAM) begin
                r_rd_cnt   <= '0;
                r_beat_cnt <= '0;
            end else begin
                if (w_rd_en) begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
                if (w_beat) begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end
        end
    end

    assign busy            = w_busy;
    assign done            = w_done;
    assign rd_en           = w_rd_en;
    assign rd_addr         = w_reads_left ? r_rd_cnt[SIZE_LOG-1:0] : LP_LAST_IDX;
    assign m00_axis_tvalid = w_valid;
    assign m00_axis_tdata  = w_valid ? w_fifo_data : '0;
    assign m00_axis_tstrb  = {(DATA_WIDTH/8){w_valid}};
    assign m00_axis_tlast  = w_valid && w_last_beat;

endmodule

// File: tb/tb_mat_out_streamer.sv
// Bench for mat_out_streamer: a cycle table for the basic packet, directed corner sequences,
// and randomized backpressure scored against the BRAM contents in row-major order.
module tb_mat_out_streamer;

    localparam int DW = 32;

    typedef struct {
        logic busy;
        logic done;
        logic rdEn;
        int   addr;
        logic tvalid;
        int   tdata;
        logic tlast;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          startA, busyA, doneA, rdEnA, tvalidA, tlastA, treadyA;
    logic [1:0]    rdAddrA;
    logic [DW-1:0] rdDataA, tdataA;
    logic [3:0]    tstrbA;
    logic          startB, busyB, doneB, rdEnB, tvalidB, tlastB, treadyB;
    logic [3:0]    rdAddrB;
    logic [DW-1:0] rdDataB, tdataB;
    logic [3:0]    tstrbB;

    logic [DW-1:0] mem [2][16];
    logic [6:0]    bpPattern = 7'b1101001;
    vec_t          basicVec [8];

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    bit monOn = 1'b0;
    int reads [2], beats [2], doneCnt [2], maxAddr [2], firstHs [2], lastHs [2];
    bit doneDue [2], prevValid [2], prevReady [2], prevLast [2];
    logic [DW-1:0] prevData [2];

    mat_out_streamer #(.DIM_LOG(1), .DATA_WIDTH(DW)) dutA (
        .s00_axi_aclk(clk), .s00_axi_areset(rst), .start(startA), .busy(busyA), .done(doneA),
        .rd_en(rdEnA), .rd_addr(rdAddrA), .rd_data(rdDataA), .m00_axis_tvalid(tvalidA),
        .m00_axis_tdata(tdataA), .m00_axis_tstrb(tstrbA), .m00_axis_tlast(tlastA),
        .m00_axis_tready(treadyA)
    );

    mat_out_streamer #(.DIM_LOG(2), .DATA_WIDTH(DW)) dutB (
        .s00_axi_aclk(clk), .s00_axi_areset(rst), .start(startB), .busy(busyB), .done(doneB),
        .rd_en(rdEnB), .rd_addr(rdAddrB), .rd_data(rdDataB), .m00_axis_tvalid(tvalidB),
        .m00_axis_tdata(tdataB), .m00_axis_tstrb(tstrbB), .m00_axis_tlast(tlastB),
        .m00_axis_tready(treadyB)
    );

    always #5 clk = ~clk;

    // Result BRAMs: data appears one cycle after the read-enable edge.
    always @(posedge clk) begin
        if (rdEnA) rdDataA <= mem[0][rdAddrA];
        if (rdEnB) rdDataB <= mem[1][rdAddrB];
    end

    function automatic int sizeOf(input int d);
        return (d == 0) ? 4 : 16;
    endfunction

    function automatic logic isBusy(input int d);
        return (d == 0) ? busyA : busyB;
    endfunction

    function automatic logic readyFor(input int mode, input int c);
        if (mode == 1) return (c >= 3 && c < 10) ? bpPattern[c - 3] : 1'b1;
        if (mode == 2) return ($urandom_range(0, 3) != 0);
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int d, input logic st, input logic rdy);
        if (d == 0) begin
            startA = st;
            treadyA = rdy;
        end else begin
            startB = st;
            treadyB = rdy;
        end
    endtask

    task automatic resetModel(input int d);
        reads[d] = 0; beats[d] = 0; doneCnt[d] = 0; maxAddr[d] = 0;
        firstHs[d] = -1; lastHs[d] = -1;
        doneDue[d] = 1'b0; prevValid[d] = 1'b0; prevReady[d] = 1'b0; prevLast[d] = 1'b0;
        prevData[d] = '0;
    endtask

    task automatic checkAllZero(input string tag, input logic b, dn, re, input logic [DW-1:0] ad,
                                input logic tv, input logic [DW-1:0] td, input logic [3:0] ts,
                                input logic tl);
        checkOutput({tag, " busy"}, 32'(b), 32'(0));
        checkOutput({tag, " done"}, 32'(dn), 32'(0));
        checkOutput({tag, " rd_en"}, 32'(re), 32'(0));
        checkOutput({tag, " rd_addr"}, ad, 32'(0));
        checkOutput({tag, " tvalid"}, 32'(tv), 32'(0));
        checkOutput({tag, " tdata"}, td, 32'(0));
        checkOutput({tag, " tstrb"}, 32'(ts), 32'(0));
        checkOutput({tag, " tlast"}, 32'(tl), 32'(0));
    endtask

    // Scoreboard: beats must replay the BRAM in address order, one done after the last beat.
    task automatic monitorStep(input int d, input logic busy, done, rdEn, input int addr,
                               input logic tvalid, input logic [DW-1:0] tdata,
                               input logic [3:0] tstrb, input logic tlast, tready);
        bit hs;
        hs = tvalid && tready;
        checkOutput("done timing", 32'(done), 32'(doneDue[d]));
        if (done) doneCnt[d]++;
        if (!busy) begin
            checkOutput("idle rd_en", 32'(rdEn), 32'(0));
            checkOutput("idle tvalid", 32'(tvalid), 32'(0));
        end
        checkOutput("tstrb", 32'(tstrb), tvalid ? 32'hF : 32'h0);
        if (prevValid[d] && !prevReady[d]) begin
            checkOutput("hold tvalid", 32'(tvalid), 32'(1));
            checkOutput("hold tdata", tdata, prevData[d]);
            checkOutput("hold tlast", 32'(tlast), 32'(prevLast[d]));
        end
        if (rdEn) begin
            checkOutput("rd_addr order", 32'(addr), 32'(reads[d]));
            checkOutput("fifo room", 32'((reads[d] + 1 - beats[d] - int'(hs)) <= 2), 32'(1));
            if (addr > maxAddr[d]) maxAddr[d] = addr;
            reads[d]++;
        end
        doneDue[d] = 1'b0;
        if (hs) begin
            if (beats[d] >= sizeOf(d)) begin
                checkOutput("beat count", 32'(beats[d] + 1), 32'(sizeOf(d)));
            end else begin
                checkOutput("beat data", tdata, mem[d][beats[d]]);
                checkOutput("beat tlast", 32'(tlast), 32'(beats[d] == sizeOf(d) - 1));
            end
            if (beats[d] == 0) firstHs[d] = cycle;
            lastHs[d] = cycle;
            beats[d]++;
            if (beats[d] == sizeOf(d)) doneDue[d] = 1'b1;
        end
        prevValid[d] = tvalid;
        prevReady[d] = tready;
        prevData[d]  = tdata;
        prevLast[d]  = tlast;
    endtask

    always @(negedge clk) begin
        cycle++;
        if (!rst && monOn) begin
            monitorStep(0, busyA, doneA, rdEnA, int'(rdAddrA), tvalidA, tdataA, tstrbA, tlastA, treadyA);
            monitorStep(1, busyB, doneB, rdEnB, int'(rdAddrB), tvalidB, tdataB, tstrbB, tlastB, treadyB);
        end
    end

    task automatic waitDone(input int d, input int budget);
        int c = 0;
        while (doneCnt[d] == 0 && c < budget) begin
            @(negedge clk); #1;
            c++;
        end
        checkOutput("done within budget", 32'(doneCnt[d] != 0), 32'(1));
    endtask

    task automatic runStream(input int d, input int mode, input int budget);
        bit finished = 1'b0;
        resetModel(d);
        applyStimulus(d, 1'b1, readyFor(mode, 0));
        for (int c = 1; c < budget && !finished; c++) begin
            @(posedge clk); #2;
            applyStimulus(d, (mode == 2 || (mode == 3 && (c == 2 || c == 4))) && isBusy(d)
                             && (mode == 3 || $urandom_range(0, 3) == 0), readyFor(mode, c));
            if (doneCnt[d] != 0) finished = 1'b1;
        end
        checkOutput("run completes", 32'(finished), 32'(1));
        applyStimulus(d, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checkOutput("beats per run", 32'(beats[d]), 32'(sizeOf(d)));
        checkOutput("done pulses", 32'(doneCnt[d]), 32'(1));
        checkOutput("reads per run", 32'(reads[d]), 32'(sizeOf(d)));
        @(posedge clk); #2;
    endtask

    initial begin
        // k = cycle after the edge that samples start: busy, done, rd_en, addr, tvalid, tdata, tlast
        basicVec[0] = '{busy: 1'b1, done: 1'b0, rdEn: 1'b1, addr: 0, tvalid: 1'b0, tdata: 0,  tlast: 1'b0};
        basicVec[1] = '{busy: 1'b1, done: 1'b0, rdEn: 1'b1, addr: 1, tvalid: 1'b0, tdata: 0,  tlast: 1'b0};
        basicVec[2] = '{busy: 1'b1, done: 1'b0, rdEn: 1'b1, addr: 2, tvalid: 1'b1, tdata: 10, tlast: 1'b0};
        basicVec[3] = '{busy: 1'b1, done: 1'b0, rdEn: 1'b1, addr: 3, tvalid: 1'b1, tdata: 20, tlast: 1'b0};
        basicVec[4] = '{busy: 1'b1, done: 1'b0, rdEn: 1'b0, addr: 0, tvalid: 1'b1, tdata: 30, tlast: 1'b0};
        basicVec[5] = '{busy: 1'b1, done: 1'b0, rdEn: 1'b0, addr: 0, tvalid: 1'b1, tdata: 40, tlast: 1'b1};
        basicVec[6] = '{busy: 1'b0, done: 1'b1, rdEn: 1'b0, addr: 0, tvalid: 1'b0, tdata: 0,  tlast: 1'b0};
        basicVec[7] = '{busy: 1'b0, done: 1'b0, rdEn: 1'b0, addr: 0, tvalid: 1'b0, tdata: 0,  tlast: 1'b0};

        for (int i = 0; i < 16; i++) begin
            mem[0][i] = (i < 4) ? 32'(10 * (i + 1)) : 32'(0);
            mem[1][i] = 32'(i);
        end
        resetModel(0);
        resetModel(1);
        applyStimulus(0, 1'b0, 1'b1);
        applyStimulus(1, 1'b0, 1'b1);

        #1 rst = 1'b1;
        #1;
        checkAllZero("reset A", busyA, doneA, rdEnA, 32'(rdAddrA), tvalidA, tdataA, tstrbA, tlastA);
        checkAllZero("reset B", busyB, doneB, rdEnB, 32'(rdAddrB), tvalidB, tdataB, tstrbB, tlastB);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        monOn = 1'b1;

        $display("[TB] basic stream, DIM_LOG=1");
        resetModel(0);
        applyStimulus(0, 1'b1, 1'b1);
        @(posedge clk); #2;
        applyStimulus(0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            checkOutput($sformatf("basic[%0d] busy", k), 32'(busyA), 32'(basicVec[k].busy));
            checkOutput($sformatf("basic[%0d] done", k), 32'(doneA), 32'(basicVec[k].done));
            checkOutput($sformatf("basic[%0d] rd_en", k), 32'(rdEnA), 32'(basicVec[k].rdEn));
            checkOutput($sformatf("basic[%0d] tvalid", k), 32'(tvalidA), 32'(basicVec[k].tvalid));
            checkOutput($sformatf("basic[%0d] tlast", k), 32'(tlastA), 32'(basicVec[k].tlast));
            if (basicVec[k].rdEn)
                checkOutput($sformatf("basic[%0d] rd_addr", k), 32'(rdAddrA), 32'(basicVec[k].addr));
            if (basicVec[k].tvalid)
                checkOutput($sformatf("basic[%0d] tdata", k), tdataA, 32'(basicVec[k].tdata));
        end
        checkOutput("basic beats", 32'(beats[0]), 32'(4));
        checkOutput("basic done pulses", 32'(doneCnt[0]), 32'(1));
        @(posedge clk); #2;

        $display("[TB] backpressure pattern");
        runStream(0, 1, 60);

        $display("[TB] stall at start");
        resetModel(0);
        applyStimulus(0, 1'b1, 1'b0);
        @(posedge clk); #2;
        applyStimulus(0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk); #1;
        checkOutput("stall reads", 32'(reads[0]), 32'(2));
        checkOutput("stall tvalid", 32'(tvalidA), 32'(1));
        checkOutput("stall tdata", tdataA, 32'(10));
        checkOutput("stall tlast", 32'(tlastA), 32'(0));
        @(posedge clk); #2;
        applyStimulus(0, 1'b0, 1'b1);
        waitDone(0, 40);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("stall beats", 32'(beats[0]), 32'(4));
        checkOutput("stall done pulses", 32'(doneCnt[0]), 32'(1));
        @(posedge clk); #2;

        $display("[TB] reset mid-stream");
        resetModel(0);
        applyStimulus(0, 1'b1, 1'b1);
        @(posedge clk); #2;
        applyStimulus(0, 1'b0, 1'b1);
        for (int c = 0; c < 20 && beats[0] < 2; c++) begin
            @(negedge clk); #1;
        end
        checkOutput("two beats before reset", 32'(beats[0]), 32'(2));
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkAllZero("mid reset", busyA, doneA, rdEnA, 32'(rdAddrA), tvalidA, tdataA, tstrbA, tlastA);
        @(posedge clk); #2;
        rst = 1'b0;
        runStream(0, 0, 40);

        $display("[TB] start while busy");
        runStream(0, 3, 40);

        $display("[TB] DIM_LOG=2 full rate");
        runStream(1, 0, 80);
        checkOutput("max rd_addr", 32'(maxAddr[1]), 32'(15));
        checkOutput("full-rate span", 32'(lastHs[1] - firstHs[1]), 32'(15));

        $display("[TB] randomized backpressure and stray starts");
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < sizeOf(r % 2); i++) mem[r % 2][i] = $urandom;
            runStream(r % 2, 2, 400);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
